// File: rtl/instr_prefetch_buf_pkg.sv
// Shared types and defaults for the instruction prefetch buffer.
// The state constants mirror pf_state_e so legacy code can keep plain logic vectors.
package instr_prefetch_buf_pkg;

  localparam int InstAddrBus   = 32;
  localparam int InstBus       = 32;
  localparam int PrefetchDepth = 4;

  typedef enum logic [1:0] {
    PF_IDLE  = 2'd0,
    PF_FETCH = 2'd1,
    PF_DRAIN = 2'd2
  } pf_state_e;

  localparam logic [1:0] ST_IDLE  = PF_IDLE;
  localparam logic [1:0] ST_FETCH = PF_FETCH;
  localparam logic [1:0] ST_DRAIN = PF_DRAIN;

  typedef struct packed {
    logic [InstAddrBus-1:0] tag;
    logic [InstBus-1:0]     data;
  } pf_entry_t;

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Tagged synchronous FIFO holding prefetched {address, instruction} pairs.
// Clear wins over push; a push into a full FIFO is accepted only alongside a pop.
module instr_prefetch_fifo
  import instr_prefetch_buf_pkg::*;
#(
  parameter int DEPTH  = PrefetchDepth,
  parameter int ADDR_W = InstAddrBus,
  parameter int DATA_W = InstBus
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [ADDR_W-1:0]        push_tag_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [ADDR_W-1:0]        head_tag_o,
  output logic [DATA_W-1:0]        head_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(DEPTH);

  logic [ADDR_W-1:0] tag_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o      = (count_q == DEPTH_CNT);
  assign empty_o     = (count_q == {PTR_W{1'b0}});
  assign count_o     = count_q;
  assign head_tag_o  = tag_q[rd_ptr_q[IDX_W-1:0]];
  assign head_data_o = data_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = {PTR_W{1'b0}};
    end else begin
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (do_push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      count_d = count_q + PTR_W'(do_push) - PTR_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {PTR_W{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is qualified by count_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) begin
      tag_q[wr_ptr_q[IDX_W-1:0]]  <= push_tag_i;
      data_q[wr_ptr_q[IDX_W-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/instr_prefetch_buf.sv
// Instruction prefetch buffer: runs sequentially ahead of the core, serves hits with
// zero added latency and redirects on any non-sequential fetch address.
module instr_prefetch_buf
  import instr_prefetch_buf_pkg::*;
#(
  parameter int DEPTH  = PrefetchDepth,
  parameter int ADDR_W = InstAddrBus,
  parameter int DATA_W = InstBus
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  output logic [DATA_W-1:0] core_data_o,
  output logic              core_ready_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ready_i,
  input  logic              hold_i,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0]  DEPTH_CNT = PTR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] WORD_INC  = ADDR_W'(32'd4);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;

  logic              f_full;
  logic              f_empty;
  logic [ADDR_W-1:0] f_head_tag;
  logic [DATA_W-1:0] f_head_data;
  logic [PTR_W-1:0]  f_count;

  logic              head_hit;
  logic              inflight_match;
  logic              bypass_hit;
  logic              miss;
  logic              push;
  logic [PTR_W-1:0]  count_next;
  logic              space_next;
  logic              start;

  instr_prefetch_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_tag_i  (req_addr_q),
    .push_data_i (mem_data_i),
    .pop_i       (head_hit),
    .clear_i     (miss),
    .full_o      (f_full),
    .empty_o     (f_empty),
    .head_tag_o  (f_head_tag),
    .head_data_o (f_head_data),
    .count_o     (f_count)
  );

  // A core that keeps asking for the word already on the bus is waiting, not jumping;
  // treating that as a miss would drain and re-request it forever.
  always_comb begin
    head_hit       = core_req_i & ~f_empty & (f_head_tag == core_addr_i);
    inflight_match = core_req_i & f_empty & (state_q == ST_FETCH) & (req_addr_q == core_addr_i);
    bypass_hit     = inflight_match & mem_ready_i;
    miss           = core_req_i & ~head_hit & ~inflight_match;
    push           = (state_q == ST_FETCH) & mem_ready_i & ~miss & ~bypass_hit & (~f_full | head_hit);
    if (miss) begin
      count_next = {PTR_W{1'b0}};
    end else begin
      count_next = f_count + PTR_W'(push) - PTR_W'(head_hit);
    end
    space_next = (count_next < DEPTH_CNT);
  end

  always_comb begin
    if (head_hit) begin
      core_data_o = f_head_data;
    end else if (bypass_hit) begin
      core_data_o = mem_data_i;
    end else begin
      core_data_o = {DATA_W{1'b0}};
    end
    core_ready_o = head_hit | bypass_hit;
    mem_req_o    = (state_q == ST_FETCH) | (state_q == ST_DRAIN);
    mem_addr_o   = mem_req_o ? req_addr_q : {ADDR_W{1'b0}};
    empty_o      = f_empty;
  end

  // Bus requests are never cancelled: a miss mid-flight parks in DRAIN until the stale word lands.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    start      = 1'b0;
    if (miss) begin
      fetch_ptr_d = core_addr_i;
    end else begin
      fetch_ptr_d = fetch_ptr_q;
    end
    case (state_q)
      ST_IDLE: begin
        start = ~hold_i & space_next;
      end
      ST_FETCH: begin
        if (mem_ready_i) begin
          if (!miss) begin
            fetch_ptr_d = fetch_ptr_q + WORD_INC;
          end else begin
            fetch_ptr_d = core_addr_i;
          end
          start   = ~hold_i & space_next;
          state_d = ST_IDLE;
        end else if (miss) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (mem_ready_i) begin
          start   = ~hold_i & space_next;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (start) begin
      state_d    = ST_FETCH;
      req_addr_d = fetch_ptr_d;
    end else begin
      req_addr_d = req_addr_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      fetch_ptr_q <= {ADDR_W{1'b0}};
      req_addr_q  <= {ADDR_W{1'b0}};
    end else begin
      state_q     <= state_d;
      fetch_ptr_q <= fetch_ptr_d;
      req_addr_q  <= req_addr_d;
    end
  end

endmodule
